// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: streams one N-sample frame from a sample ROM into an FFT
// core and captures the returned spectrum into a RAM, flagging framing faults.
module fft_frame_ctrl #(
  parameter int N_LOG2  = 12,
  parameter int DW      = 12,
  parameter int TIMEOUT = 16383
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [N_LOG2-1:0] smp_addr,
  output logic              smp_rden,
  input  logic [DW-1:0]     smp_data,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DW-1:0]     sink_real,
  input  logic              sink_ready,
  input  logic              source_valid,
  input  logic              source_sop,
  input  logic              source_eop,
  input  logic [DW-1:0]     source_real,
  input  logic [DW-1:0]     source_imag,
  output logic              source_ready,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr,
  output logic [DW-1:0]     wr_re,
  output logic [DW-1:0]     wr_im
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [N_LOG2-1:0] K_LAST   = '1;
  localparam logic [N_LOG2-1:0] K_ONE    = N_LOG2'(1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]     TMO_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_CAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [N_LOG2-1:0] k_q, k_d;
  logic [N_LOG2-1:0] b_q, b_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [N_LOG2-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_re_q, wr_re_d;
  logic [DW-1:0]     wr_im_q, wr_im_d;

  logic in_load;
  logic in_rx;
  logic sink_acc;
  logic src_acc;
  logic frame_bad;

  // Handshakes and ROM addressing; the next ROM read is issued on the accept.
  always_comb begin
    in_load      = (state_q == S_LOAD);
    in_rx        = (state_q == S_WAIT) || (state_q == S_CAP);
    sink_acc     = in_load && sink_ready;
    src_acc      = in_rx && source_valid;
    frame_bad    = source_sop || (source_eop != (b_q == K_LAST));
    busy         = (state_q != S_IDLE);
    smp_rden     = (!sys_rst && (state_q == S_IDLE) && start) || sink_acc;
    smp_addr     = sink_acc ? (k_q + K_ONE) : k_q;
    sink_valid   = in_load;
    sink_sop     = in_load && (k_q == '0);
    sink_eop     = in_load && (k_q == K_LAST);
    sink_real    = in_load ? smp_data : '0;
    source_ready = in_rx;
  end

  // Frame sequencing, load/bin counters, timeout and capture registers.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    b_d       = b_q;
    tmo_d     = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_re_d   = wr_re_q;
    wr_im_d   = wr_im_q;
    unique case (state_q)
      S_IDLE: begin
        k_d = '0;
        b_d = '0;
        if (start) begin
          state_d = S_PRIME;
        end
      end
      S_PRIME: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (sink_acc) begin
          k_d = k_q + K_ONE;
          if (k_q == K_LAST) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + TMO_ONE;
        if (src_acc && source_sop) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_re_d   = source_real;
          wr_im_d   = source_imag;
          if (source_eop) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            b_d     = K_ONE;
            state_d = S_CAP;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CAP: begin
        if (src_acc) begin
          wr_en_d   = 1'b1;
          wr_addr_d = b_q;
          wr_re_d   = source_real;
          wr_im_d   = source_imag;
          if (frame_bad) begin
            err_d   = 1'b1;
            b_d     = '0;
            state_d = S_IDLE;
          end else if (b_q == K_LAST) begin
            done_d  = 1'b1;
            b_d     = '0;
            state_d = S_DONE;
          end else begin
            b_d = b_q + K_ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      b_q       <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_re_q   <= '0;
      wr_im_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      b_q       <= b_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_re_q   <= wr_re_d;
      wr_im_q   <= wr_im_d;
    end
  end

  assign done    = done_q;
  assign err     = err_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_re   = wr_re_q;
  assign wr_im   = wr_im_q;

  // Completion and error are mutually exclusive outcomes of a frame.
  a_done_err_excl: assert property (
    @(posedge sys_clk) disable iff (sys_rst) !(done_q && err_q)
  );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed scenarios for fft_frame_ctrl with N=16,
// a ROM holding ROM[i]=i and a hand-driven FFT output stream.
module tb_fft_frame_ctrl;
  localparam int NL  = 4;
  localparam int N   = 16;
  localparam int DW  = 12;
  localparam int TMO = 40;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic [NL-1:0] smp_addr;
  logic          smp_rden;
  logic [DW-1:0] smp_data;
  logic          sink_valid;
  logic          sink_sop;
  logic          sink_eop;
  logic [DW-1:0] sink_real;
  logic          sink_ready;
  logic          source_valid;
  logic          source_sop;
  logic          source_eop;
  logic [DW-1:0] source_real;
  logic [DW-1:0] source_imag;
  logic          source_ready;
  logic          wr_en;
  logic [NL-1:0] wr_addr;
  logic [DW-1:0] wr_re;
  logic [DW-1:0] wr_im;

  int tests = 0;
  int fails = 0;

  fft_frame_ctrl #(.N_LOG2(NL), .DW(DW), .TIMEOUT(TMO)) dut (
    .sys_clk     (clk),
    .sys_rst     (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .smp_addr    (smp_addr),
    .smp_rden    (smp_rden),
    .smp_data    (smp_data),
    .sink_valid  (sink_valid),
    .sink_sop    (sink_sop),
    .sink_eop    (sink_eop),
    .sink_real   (sink_real),
    .sink_ready  (sink_ready),
    .source_valid(source_valid),
    .source_sop  (source_sop),
    .source_eop  (source_eop),
    .source_real (source_real),
    .source_imag (source_imag),
    .source_ready(source_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_re       (wr_re),
    .wr_im       (wr_im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample ROM: ROM[i] = i, registered output holding while rden is low.
  logic [DW-1:0] rom_q = 12'habc;
  assign smp_data = rom_q;
  always @(posedge clk) begin
    if (smp_rden) rom_q <= DW'(smp_addr);
  end

  wire [3*DW+2*NL+8:0] outs = {busy, done, err, smp_addr, smp_rden,
    sink_valid, sink_sop, sink_eop, sink_real, source_ready,
    wr_en, wr_addr, wr_re, wr_im};

  // Observation logs, sampled mid-cycle.
  logic [DW-1:0] sink_v[$];
  logic [NL-1:0] wr_a[$];
  logic [DW-1:0] wr_r[$];
  logic [DW-1:0] wr_i[$];
  int sop_n, eop_n, sop_val, eop_val;
  int rden_bad, done_n, err_n, both_n;

  always @(negedge clk) begin
    if (sink_valid && sink_ready) begin
      sink_v.push_back(sink_real);
      if (sink_sop) begin sop_n++; sop_val = int'(sink_real); end
      if (sink_eop) begin eop_n++; eop_val = int'(sink_real); end
      if (!smp_rden) rden_bad++;
    end else if (smp_rden && busy) begin
      rden_bad++;
    end
    if (wr_en) begin
      wr_a.push_back(wr_addr);
      wr_r.push_back(wr_re);
      wr_i.push_back(wr_im);
    end
    if (done) done_n++;
    if (err) err_n++;
    if (done && err) both_n++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    sink_v.delete();
    wr_a.delete();
    wr_r.delete();
    wr_i.delete();
    sop_n = 0; eop_n = 0; sop_val = -1; eop_val = -1;
    rden_bad = 0; done_n = 0; err_n = 0; both_n = 0;
  endtask

  // Drive sink_ready from a 4-cycle pattern until the eop beat is accepted.
  task automatic finish_load(input logic [3:0] pat, input int start_at,
                             output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      start = (i == start_at);
      sink_ready = pat[2'(i)];
      #1;
      if (sink_valid && sink_ready && sink_eop) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic run_load(input logic [3:0] pat, input int start_at,
                          output bit ok);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    finish_load(pat, start_at, ok);
  endtask

  // FFT output model: sop on beat 0 and sop2_at, eop on eop_at.
  task automatic emit(input int nb, input int eop_at, input int sop2_at);
    for (int i = 0; i < nb; i++) begin
      source_valid = 1'b1;
      source_sop   = (i == 0) || (i == sop2_at);
      source_eop   = (i == eop_at);
      source_real  = DW'(100 + i);
      source_imag  = DW'(500 + i);
      tick();
    end
    source_valid = 1'b0;
    source_sop   = 1'b0;
    source_eop   = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    tests++;
    if (outs !== '0) begin
      fails++;
      $display("FAIL reset_outs: got %h, required all zero", outs);
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || smp_rden !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: busy=%b rden=%b, required 0 0",
               busy, smp_rden);
    end
  endtask

  task automatic test_frame();
    bit ok;
    int bad;
    clr();
    sink_ready = 1'b1;
    start = 1'b1;
    #1;
    tests++;
    if (smp_rden !== 1'b1 || smp_addr !== 4'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_start: rden=%b addr=%0d busy=%b, required 1 0 0",
               smp_rden, smp_addr, busy);
    end
    tick();
    start = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b1 || sink_valid !== 1'b0 || smp_rden !== 1'b0) begin
      fails++;
      $display("FAIL prime: busy=%b valid=%b rden=%b, required 1 0 0",
               busy, sink_valid, smp_rden);
    end
    tick();
    tests++;
    if (sink_valid !== 1'b1 || sink_sop !== 1'b1 || sink_real !== 12'd0 ||
        smp_addr !== 4'd1 || smp_rden !== 1'b1 || source_ready !== 1'b0) begin
      fails++;
      $display("FAIL load_k0: v=%b sop=%b real=%0d addr=%0d rden=%b sr=%b, required 1 1 0 1 1 0",
               sink_valid, sink_sop, sink_real, smp_addr, smp_rden,
               source_ready);
    end
    finish_load(4'b1111, -1, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL load_bound: eop never accepted, required within 200 cycles");
    end
    tick();
    tick();
    tests++;
    if (busy !== 1'b1 || source_ready !== 1'b1 || sink_valid !== 1'b0 ||
        smp_addr !== 4'd0) begin
      fails++;
      $display("FAIL wait_state: busy=%b sr=%b v=%b addr=%0d, required 1 1 0 0",
               busy, source_ready, sink_valid, smp_addr);
    end
    emit(N, N - 1, -1);
    bad = 0;
    foreach (sink_v[i]) if (sink_v[i] !== DW'(i)) bad++;
    tests++;
    if (sink_v.size() != N || bad != 0 || sop_n != 1 || sop_val != 0 ||
        eop_n != 1 || eop_val != N - 1) begin
      fails++;
      $display("FAIL frame_sink: beats=%0d bad=%0d sop=%0d@%0d eop=%0d@%0d, required 16 0 1@0 1@15",
               sink_v.size(), bad, sop_n, sop_val, eop_n, eop_val);
    end
    bad = 0;
    foreach (wr_a[i]) begin
      if (wr_a[i] !== NL'(i) || wr_r[i] !== DW'(100 + i) ||
          wr_i[i] !== DW'(500 + i)) bad++;
    end
    tests++;
    if (wr_a.size() != N || bad != 0) begin
      fails++;
      $display("FAIL frame_writes: writes=%0d bad=%0d, required 16 0",
               wr_a.size(), bad);
    end
    tests++;
    if (done_n != 1 || err_n != 0 || both_n != 0 || busy !== 1'b0 ||
        rden_bad != 0) begin
      fails++;
      $display("FAIL frame_status: done=%0d err=%0d both=%0d busy=%b rdenbad=%0d, required 1 0 0 0 0",
               done_n, err_n, both_n, busy, rden_bad);
    end
  endtask

  task automatic test_ready_toggle();
    bit ok;
    int bad;
    clr();
    run_load(4'b1001, 5, ok);
    tick();
    tick();
    emit(N, N - 1, -1);
    tick();
    tick();
    bad = 0;
    foreach (sink_v[i]) if (sink_v[i] !== DW'(i)) bad++;
    tests++;
    if (!ok || sink_v.size() != N || bad != 0 || rden_bad != 0) begin
      fails++;
      $display("FAIL toggle_seq: ok=%b beats=%0d bad=%0d rdenbad=%0d, required 1 16 0 0",
               ok, sink_v.size(), bad, rden_bad);
    end
    tests++;
    if (done_n != 1 || err_n != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL toggle_status: done=%0d err=%0d busy=%b, required 1 0 0 (start during load ignored)",
               done_n, err_n, busy);
    end
  endtask

  task automatic test_framing_err();
    bit ok;
    int bad;
    clr();
    run_load(4'b1111, -1, ok);
    tick();
    tick();
    emit(N, 9, -1);
    bad = 0;
    foreach (wr_a[i]) if (wr_a[i] !== NL'(i)) bad++;
    tests++;
    if (wr_a.size() != 10 || bad != 0 || err_n != 1 || done_n != 0 ||
        busy !== 1'b0) begin
      fails++;
      $display("FAIL early_eop: writes=%0d bad=%0d err=%0d done=%0d busy=%b, required 10 0 1 0 0",
               wr_a.size(), bad, err_n, done_n, busy);
    end
    clr();
    run_load(4'b1111, -1, ok);
    tick();
    emit(N, -1, -1);
    tests++;
    if (wr_a.size() != N || err_n != 1 || done_n != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL missing_eop: writes=%0d err=%0d done=%0d busy=%b, required 16 1 0 0",
               wr_a.size(), err_n, done_n, busy);
    end
    clr();
    run_load(4'b1111, -1, ok);
    tick();
    emit(N, N - 1, 5);
    tests++;
    if (wr_a.size() != 6 || err_n != 1 || done_n != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL second_sop: writes=%0d err=%0d done=%0d busy=%b, required 6 1 0 0",
               wr_a.size(), err_n, done_n, busy);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen;
    int w;
    clr();
    run_load(4'b1111, -1, ok);
    w = 0;
    seen = 1'b0;
    for (int c = 0; c < TMO + 20; c++) begin
      tick();
      if (err) begin
        seen = 1'b1;
        break;
      end
      if (source_ready) w++;
      source_valid = (c < 5);
      source_sop   = 1'b0;
      source_real  = DW'(c);
      source_imag  = DW'(c);
    end
    source_valid = 1'b0;
    tests++;
    if (!seen || w != TMO || wr_a.size() != 0) begin
      fails++;
      $display("FAIL timeout_at: seen=%b wait_cycles=%0d writes=%0d, required 1 40 0",
               seen, w, wr_a.size());
    end
    tick();
    tests++;
    if (busy !== 1'b0 || err !== 1'b0 || err_n != 1 || done_n != 0) begin
      fails++;
      $display("FAIL timeout_after: busy=%b err=%b errs=%0d done=%0d, required 0 0 1 0",
               busy, err, err_n, done_n);
    end
  endtask

  task automatic test_back_to_back();
    int bi, gap, gap_min, frames, bad;
    bit pb;
    clr();
    bi = 0; gap = 0; gap_min = 99; frames = 0; pb = 1'b0;
    sink_ready = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 400 && done_n < 2; c++) begin
      tick();
      if (busy && !pb) begin
        frames++;
        if (frames > 1 && gap < gap_min) gap_min = gap;
      end
      if (!busy) gap++;
      else gap = 0;
      pb = busy;
      if (source_ready) begin
        source_valid = 1'b1;
        source_sop   = (bi == 0);
        source_eop   = (bi == N - 1);
        source_real  = DW'(100 + bi);
        source_imag  = DW'(500 + bi);
        bi++;
      end else begin
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        bi = 0;
      end
    end
    start = 1'b0;
    source_valid = 1'b0;
    tick();
    tick();
    tick();
    tests++;
    if (done_n != 2 || err_n != 0 || frames != 2 || gap_min < 1 ||
        sop_n != 2 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_frames: done=%0d err=%0d frames=%0d gap=%0d sops=%0d busy=%b, required 2 0 2 >=1 2 0",
               done_n, err_n, frames, gap_min, sop_n, busy);
    end
    bad = 0;
    foreach (wr_a[i]) if (wr_a[i] !== NL'(i % N)) bad++;
    tests++;
    if (wr_a.size() != 2 * N || bad != 0) begin
      fails++;
      $display("FAIL b2b_writes: writes=%0d bad=%0d, required 32 0",
               wr_a.size(), bad);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    int bad;
    clr();
    found = 1'b0;
    sink_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 40; i++) begin
      #1;
      if (sink_valid && sink_real == 12'd7) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    rst = 1'b1;
    start = 1'b1;
    #1;
    tests++;
    if (!found || outs !== '0) begin
      fails++;
      $display("FAIL reset_mid_outs: found=%b outs=%h, required 1 all zero",
               found, outs);
    end
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    tests++;
    if (done_n != 0 || err_n != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_pulse: done=%0d err=%0d busy=%b, required 0 0 0",
               done_n, err_n, busy);
    end
    clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests++;
    if (sink_valid !== 1'b1 || sink_sop !== 1'b1 || sink_real !== 12'd0) begin
      fails++;
      $display("FAIL reset_restart: v=%b sop=%b real=%0d, required 1 1 0",
               sink_valid, sink_sop, sink_real);
    end
    finish_load(4'b1111, -1, ok);
    tick();
    emit(N, N - 1, -1);
    bad = 0;
    foreach (sink_v[i]) if (sink_v[i] !== DW'(i)) bad++;
    tests++;
    if (!ok || sink_v.size() != N || bad != 0 || done_n != 1 ||
        err_n != 0 || wr_a.size() != N) begin
      fails++;
      $display("FAIL reset_refrm: ok=%b beats=%0d bad=%0d done=%0d err=%0d writes=%0d, required 1 16 0 1 0 16",
               ok, sink_v.size(), bad, done_n, err_n, wr_a.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sink_ready = 1'b0;
    source_valid = 1'b0;
    source_sop = 1'b0;
    source_eop = 1'b0;
    source_real = '0;
    source_imag = '0;
    clr();
    test_reset();
    test_frame();
    test_ready_toggle();
    test_framing_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
